// File: rtl/lsu_ext_reqbuf.sv
// External load/store request buffer between the LSU dc3 stage and the system bus.
// In-order FIFO issue, outstanding-transaction tracking, and strict side-effect ordering.
module lsu_ext_reqbuf #(
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 4,
  localparam int TAGW = $clog2(MAX_OUT)
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            scan_mode,
  input  logic            enq_valid_dc3,
  input  logic [31:0]     enq_addr_dc3,
  input  logic [1:0]      enq_size_dc3,
  input  logic            enq_write_dc3,
  input  logic [31:0]     enq_wdata_dc3,
  input  logic            enq_sideeffects_dc3,
  output logic            enq_full,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic [31:0]     bus_req_addr,
  output logic [1:0]      bus_req_size,
  output logic            bus_req_write,
  output logic [31:0]     bus_req_wdata,
  output logic [TAGW-1:0] bus_req_tag,
  input  logic            bus_rsp_valid,
  input  logic [TAGW-1:0] bus_rsp_tag,
  input  logic            bus_rsp_err,
  output logic            done_valid,
  output logic [TAGW-1:0] done_tag,
  output logic            done_err,
  output logic [TAGW:0]   out_cnt,
  output logic            proto_err,
  output logic            idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [TAGW:0]   CNT_MAX  = (TAGW+1)'(MAX_OUT);
  localparam logic [TAGW:0]   CNT_ZERO = (TAGW+1)'(0);
  localparam logic [TAGW:0]   CNT_ONE  = (TAGW+1)'(1);
  localparam logic [TAGW-1:0] TAG_ZERO = TAGW'(0);
  localparam logic [TAGW-1:0] TAG_ONE  = TAGW'(1);
  localparam logic [PW-1:0]   PTR_ZERO = PW'(0);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        write;
    logic [31:0] wdata;
    logic        se;
  } entry_t;

  localparam entry_t ENTRY_CLR = '{addr: 32'h0, size: 2'b00, write: 1'b0, wdata: 32'h0, se: 1'b0};

  entry_t            buf_r [DEPTH];
  logic [PW-1:0]     wrptr_r;
  logic [PW-1:0]     rdptr_r;
  logic [TAGW:0]     out_cnt_r;
  logic [TAGW-1:0]   iss_tag_r;
  logic [TAGW-1:0]   exp_tag_r;
  logic              se_inflight_r;
  logic              done_valid_r;
  logic [TAGW-1:0]   done_tag_r;
  logic              done_err_r;
  logic              proto_err_r;

  logic              rst_eff_n_s;
  logic              empty_s;
  logic              full_s;
  entry_t            head_s;
  logic              issue_s;
  logic              hs_s;
  logic              enq_ok_s;
  logic              enq_bad_s;
  logic              rsp_ok_s;
  logic              rsp_stray_s;
  logic              tag_mis_s;
  logic              se_inflight_nxt_s;
  logic [TAGW:0]     out_cnt_nxt_s;

  // Scan holds the asynchronous reset inactive so the flops stay under scan control.
  assign rst_eff_n_s = rst_l | scan_mode;

  assign empty_s = (wrptr_r == rdptr_r);
  assign full_s  = (wrptr_r[AW-1:0] == rdptr_r[AW-1:0]) & (wrptr_r[AW] != rdptr_r[AW]);
  assign head_s  = buf_r[rdptr_r[AW-1:0]];

  assign issue_s = ~empty_s & (out_cnt_r < CNT_MAX) &
                   (~head_s.se | (out_cnt_r == CNT_ZERO)) & ~se_inflight_r;
  assign hs_s    = issue_s & bus_req_ready;

  assign enq_ok_s  = enq_valid_dc3 & ~full_s & (enq_size_dc3 != 2'd3);
  assign enq_bad_s = enq_valid_dc3 & (full_s | (enq_size_dc3 == 2'd3));

  assign rsp_ok_s    = bus_rsp_valid & (out_cnt_r != CNT_ZERO);
  assign rsp_stray_s = bus_rsp_valid & (out_cnt_r == CNT_ZERO);
  assign tag_mis_s   = rsp_ok_s & (bus_rsp_tag != exp_tag_r);

  // A set in the same cycle as the clearing response wins.
  assign se_inflight_nxt_s = (hs_s & head_s.se) | (se_inflight_r & ~rsp_ok_s);

  // Outstanding count: issue and retire in the same cycle cancel out.
  always_comb begin
    out_cnt_nxt_s = out_cnt_r;
    case ({hs_s, rsp_ok_s})
      2'b10:   out_cnt_nxt_s = out_cnt_r + CNT_ONE;
      2'b01:   out_cnt_nxt_s = out_cnt_r - CNT_ONE;
      default: out_cnt_nxt_s = out_cnt_r;
    endcase
  end

  // Request storage written at the write pointer.
  always_ff @(posedge clk or negedge rst_eff_n_s) begin
    if (!rst_eff_n_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_r[i] <= ENTRY_CLR;
      end
    end else if (enq_ok_s) begin
      buf_r[wrptr_r[AW-1:0]] <= '{addr: enq_addr_dc3, size: enq_size_dc3, write: enq_write_dc3,
                                  wdata: enq_wdata_dc3, se: enq_sideeffects_dc3};
    end
  end

  // Pointers, tag counters, outstanding tracking, completions and sticky error.
  always_ff @(posedge clk or negedge rst_eff_n_s) begin
    if (!rst_eff_n_s) begin
      wrptr_r       <= PTR_ZERO;
      rdptr_r       <= PTR_ZERO;
      out_cnt_r     <= CNT_ZERO;
      iss_tag_r     <= TAG_ZERO;
      exp_tag_r     <= TAG_ZERO;
      se_inflight_r <= 1'b0;
      done_valid_r  <= 1'b0;
      done_tag_r    <= TAG_ZERO;
      done_err_r    <= 1'b0;
      proto_err_r   <= 1'b0;
    end else begin
      if (enq_ok_s) begin
        wrptr_r <= wrptr_r + PTR_ONE;
      end
      if (hs_s) begin
        rdptr_r   <= rdptr_r + PTR_ONE;
        iss_tag_r <= iss_tag_r + TAG_ONE;
      end
      if (rsp_ok_s) begin
        exp_tag_r  <= exp_tag_r + TAG_ONE;
        done_tag_r <= bus_rsp_tag;
      end
      out_cnt_r     <= out_cnt_nxt_s;
      se_inflight_r <= se_inflight_nxt_s;
      done_valid_r  <= rsp_ok_s;
      done_err_r    <= rsp_ok_s & (bus_rsp_err | tag_mis_s);
      if (enq_bad_s | rsp_stray_s | tag_mis_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign enq_full      = full_s;
  assign bus_req_valid = issue_s;
  assign bus_req_addr  = head_s.addr;
  assign bus_req_size  = head_s.size;
  assign bus_req_write = head_s.write;
  assign bus_req_wdata = head_s.wdata;
  assign bus_req_tag   = iss_tag_r;
  assign done_valid    = done_valid_r;
  assign done_tag      = done_tag_r;
  assign done_err      = done_err_r;
  assign out_cnt       = out_cnt_r;
  assign proto_err     = proto_err_r;
  assign idle          = empty_s & (out_cnt_r == CNT_ZERO);

endmodule
